// File: rtl/otp_decipher_if.sv
// Purpose: valid/ready bundle for the pad, ciphertext and plaintext streams of otp_decipher.
// Latency: none, this is wiring only.
// Backpressure: each stream carries its own valid/ready pair; slave is the decipher side.
interface otp_decipher_if #(
    parameter int MSG_SIZE = 8
);
    logic                key_valid;
    logic                key_ready;
    logic [MSG_SIZE-1:0] key_data;
    logic                ct_valid;
    logic                ct_ready;
    logic [MSG_SIZE-1:0] ct_data;
    logic                pt_valid;
    logic                pt_ready;
    logic [MSG_SIZE-1:0] pt_data;

    // Environment side: offers pads and ciphertext, accepts plaintext.
    modport master (
        output key_valid, key_data, ct_valid, ct_data, pt_ready,
        input  key_ready, ct_ready, pt_valid, pt_data
    );

    // Decipher side.
    modport slave (
        input  key_valid, key_data, ct_valid, ct_data, pt_ready,
        output key_ready, ct_ready, pt_valid, pt_data
    );
endinterface

// File: rtl/otp_decipher.sv
// Purpose: one-time-pad receiver, plaintext = ciphertext XOR next unused pad word (pad wiped on use).
// Latency: plaintext valid one cycle after a ct handshake; one word per cycle sustained.
// Backpressure: ct_ready drops on empty pad FIFO, held plaintext or zeroize; key_ready drops when full.
module otp_decipher #(
    parameter int MSG_SIZE  = 8,
    parameter int PAD_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         zeroize,
    otp_decipher_if.slave                bus,
    output logic [$clog2(PAD_DEPTH):0]   key_count,
    output logic [CNT_W-1:0]             msg_count
);
    localparam int AW = $clog2(PAD_DEPTH);
    localparam int KW = AW + 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e          state_q;
    out_state_e          state_d;
    logic [MSG_SIZE-1:0] pad_mem [PAD_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [MSG_SIZE-1:0] pt_data_q;
    logic                pad_full;
    logic                pad_empty;
    logic                push;
    logic                fire;

    // Full/empty come from the registered count, so a pad pushed this cycle
    // cannot feed a decode until the next one.
    assign pad_full  = (key_count == KW'(PAD_DEPTH));
    assign pad_empty = (key_count == '0);

    // Readies are forced low during reset and zeroize so no handshake can complete.
    assign bus.key_ready = rst_n && !zeroize && !pad_full;
    assign bus.ct_ready  = rst_n && !zeroize && !pad_empty &&
                           ((state_q == OUT_EMPTY) || bus.pt_ready);

    assign push = bus.key_valid && bus.key_ready;
    assign fire = bus.ct_valid  && bus.ct_ready;

    assign bus.pt_valid = (state_q == OUT_FULL);
    assign bus.pt_data  = pt_data_q;

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage next state: a fire always loads, otherwise a sink accept drains.
    always_comb begin
        state_d = state_q;
        if (zeroize) begin
            state_d = OUT_EMPTY;
        end else begin
            case (state_q)
                OUT_EMPTY: if (fire) state_d = OUT_FULL;
                OUT_FULL:  if (!fire && bus.pt_ready) state_d = OUT_EMPTY;
                default:   state_d = OUT_EMPTY;
            endcase
        end
    end

    // Plaintext register; keeps its last value after a drain, cleared by zeroize.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_data_q <= '0;
        end else if (zeroize) begin
            pt_data_q <= '0;
        end else if (fire) begin
            pt_data_q <= bus.ct_data ^ pad_mem[rd_ptr];
        end
    end

    // Pad storage: consumed head entry is wiped; push and wipe never hit the
    // same slot because that would need the FIFO to be both full and empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_mem <= '{default: '0};
        end else if (zeroize) begin
            pad_mem <= '{default: '0};
        end else begin
            if (fire) begin
                pad_mem[rd_ptr] <= '0;
            end
            if (push) begin
                pad_mem[wr_ptr] <= bus.key_data;
            end
        end
    end

    // Pointers wrap naturally at PAD_DEPTH (power of two); count tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            key_count <= '0;
        end else if (zeroize) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            key_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, fire})
                2'b10:   key_count <= key_count + KW'(1);
                2'b01:   key_count <= key_count - KW'(1);
                default: key_count <= key_count;
            endcase
        end
    end

    // Decoded-message counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_count <= '0;
        end else if (zeroize) begin
            msg_count <= '0;
        end else if (fire) begin
            msg_count <= msg_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_otp_decipher.sv
// Purpose: self-checking bench for otp_decipher (queue model plus directed literal checks).
// Latency: model applies each handshake at the clock edge; outputs compared on the falling edge.
// Backpressure: model derives readies from its own pad queue and output occupancy.
module tb_otp_decipher;
    localparam int MSG_SIZE  = 8;
    localparam int PAD_DEPTH = 4;
    localparam int CNT_W     = 8;   // narrow counter so the wrap is reachable quickly
    localparam int KW        = $clog2(PAD_DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             zeroize;
    logic [KW-1:0]    key_count;
    logic [CNT_W-1:0] msg_count;

    int checks = 0;
    int errors = 0;

    otp_decipher_if #(.MSG_SIZE(MSG_SIZE)) bus ();

    otp_decipher #(
        .MSG_SIZE (MSG_SIZE),
        .PAD_DEPTH(PAD_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .zeroize  (zeroize),
        .bus      (bus.slave),
        .key_count(key_count),
        .msg_count(msg_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [MSG_SIZE-1:0] pad_q[$];
    bit                  m_vld;
    logic [MSG_SIZE-1:0] m_pt;
    logic [CNT_W-1:0]    m_msg;

    function automatic void m_reset();
        pad_q.delete();
        m_vld = 1'b0;
        m_pt  = '0;
        m_msg = '0;
    endfunction

    function automatic bit exp_key_ready();
        return rst_n && !zeroize && (pad_q.size() < PAD_DEPTH);
    endfunction

    function automatic bit exp_ct_ready();
        return rst_n && !zeroize && (pad_q.size() > 0) && (!m_vld || bus.pt_ready);
    endfunction

    function automatic void m_step();
        bit kr;
        bit cr;
        if (zeroize) begin
            m_reset();
        end else begin
            kr = exp_key_ready();
            cr = exp_ct_ready();
            if (bus.ct_valid && cr) begin
                m_pt  = bus.ct_data ^ pad_q.pop_front();
                m_vld = 1'b1;
                m_msg = m_msg + 1'b1;
            end else if (bus.pt_ready) begin
                m_vld = 1'b0;
            end
            if (bus.key_valid && kr) pad_q.push_back(bus.key_data);
        end
    endfunction

    // Compare every cycle on the falling edge, advance the model on the rising edge.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            check("m_key_ready", 32'(bus.key_ready), 32'(exp_key_ready()));
            check("m_ct_ready",  32'(bus.ct_ready),  32'(exp_ct_ready()));
            check("m_pt_valid",  32'(bus.pt_valid),  32'(m_vld));
            check("m_pt_data",   32'(bus.pt_data),   32'(m_pt));
            check("m_key_count", 32'(key_count),     32'(pad_q.size()));
            check("m_msg_count", 32'(msg_count),     32'(m_msg));
            @(posedge clk);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        zeroize       = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = '0;
        bus.ct_valid  = 1'b0;
        bus.ct_data   = '0;
        bus.pt_ready  = 1'b1;
        #2;
        check("rst_key_ready", 32'(bus.key_ready), 32'h0);
        check("rst_ct_ready",  32'(bus.ct_ready),  32'h0);
        check("rst_pt_valid",  32'(bus.pt_valid),  32'h0);
        check("rst_key_count", 32'(key_count),     32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Basic decode: 0x5F^0x3C=0x63, 0x00^0xA5=0xA5.
        bus.key_valid = 1'b1; bus.key_data = 8'h3C; cyc();
        bus.key_data = 8'hA5; cyc();
        bus.key_valid = 1'b0;
        bus.ct_valid = 1'b1; bus.ct_data = 8'h5F;
        #1;
        check("t1_key_count2", 32'(key_count), 32'd2);
        cyc();
        bus.ct_data = 8'h00;
        #1;
        check("t1_pt0", 32'(bus.pt_data), 32'h63);
        check("t1_vld0", 32'(bus.pt_valid), 32'h1);
        cyc();
        bus.ct_valid = 1'b0;
        #1;
        check("t1_pt1", 32'(bus.pt_data), 32'hA5);
        check("t1_msg", 32'(msg_count), 32'd2);
        check("t1_kc0", 32'(key_count), 32'd0);
        cyc();

        // Fill to full, hold a 5th push, free one slot, then let it in (pointer wrap).
        bus.key_valid = 1'b1;
        bus.key_data = 8'h01; cyc();
        bus.key_data = 8'h02; cyc();
        bus.key_data = 8'h04; cyc();
        bus.key_data = 8'h08; cyc();
        bus.key_data = 8'h10;
        #1;
        check("t2_full_kr", 32'(bus.key_ready), 32'h0);
        check("t2_full_kc", 32'(key_count), 32'd4);
        for (int k = 0; k < 3; k++) cyc();
        check("t2_held_kc", 32'(key_count), 32'd4);
        bus.ct_valid = 1'b1; bus.ct_data = 8'h00;
        cyc();
        bus.ct_valid = 1'b0;
        #1;
        check("t2_kr_after", 32'(bus.key_ready), 32'h1);
        check("t2_pt_first", 32'(bus.pt_data), 32'h01);
        cyc();
        bus.key_valid = 1'b0;
        #1;
        check("t2_kc_wrap", 32'(key_count), 32'd4);
        bus.ct_valid = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        bus.ct_valid = 1'b0;
        #1;
        check("t2_pt_wrapped", 32'(bus.pt_data), 32'h10);
        check("t2_kc_empty", 32'(key_count), 32'd0);

        // Empty pad FIFO back-pressures ciphertext; pad pushed now is usable next cycle.
        cyc();
        bus.ct_valid = 1'b1; bus.ct_data = 8'h11;
        for (int k = 0; k < 3; k++) cyc();
        check("t3_blk_ctr", 32'(bus.ct_ready), 32'h0);
        check("t3_blk_vld", 32'(bus.pt_valid), 32'h0);
        bus.key_valid = 1'b1; bus.key_data = 8'hFF;
        #1;
        check("t3_same_cyc", 32'(bus.ct_ready), 32'h0);
        cyc();
        bus.key_valid = 1'b0;
        #1;
        check("t3_next_ctr", 32'(bus.ct_ready), 32'h1);
        cyc();
        bus.ct_valid = 1'b0;
        #1;
        check("t3_pt", 32'(bus.pt_data), 32'hEE);

        // Sink stall holds the word; releasing it streams one word per cycle.
        bus.key_valid = 1'b1;
        bus.key_data = 8'h11; cyc();
        bus.key_data = 8'h22; cyc();
        bus.key_data = 8'h33; cyc();
        bus.key_valid = 1'b0;
        bus.pt_ready = 1'b0;
        bus.ct_valid = 1'b1; bus.ct_data = 8'hF0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_vld", 32'(bus.pt_valid), 32'h1);
            check("t4_hold_dat", 32'(bus.pt_data), 32'hE1);
            check("t4_hold_ctr", 32'(bus.ct_ready), 32'h0);
            cyc();
        end
        bus.pt_ready = 1'b1;
        cyc();
        #1;
        check("t4_stream1", 32'(bus.pt_data), 32'hD2);
        cyc();
        bus.ct_valid = 1'b0;
        #1;
        check("t4_stream2", 32'(bus.pt_data), 32'hC3);

        // Zeroize with a pending word and pushes/fires offered in the same cycle.
        bus.key_valid = 1'b1;
        bus.key_data = 8'h0F; cyc();
        bus.key_data = 8'hAA; cyc();
        bus.key_data = 8'h55; cyc();
        bus.key_valid = 1'b0;
        bus.pt_ready = 1'b0;
        bus.ct_valid = 1'b1; bus.ct_data = 8'h00;
        cyc();
        zeroize = 1'b1;
        bus.key_valid = 1'b1; bus.key_data = 8'h77;
        bus.ct_data = 8'h12;
        bus.pt_ready = 1'b1;
        #1;
        check("t5_pend_pt", 32'(bus.pt_data), 32'h0F);
        check("t5_zkr", 32'(bus.key_ready), 32'h0);
        check("t5_zctr", 32'(bus.ct_ready), 32'h0);
        cyc();
        zeroize = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        check("t5_kc", 32'(key_count), 32'd0);
        check("t5_vld", 32'(bus.pt_valid), 32'h0);
        check("t5_dat", 32'(bus.pt_data), 32'h0);
        check("t5_msg", 32'(msg_count), 32'd0);
        check("t5_ctr_blk", 32'(bus.ct_ready), 32'h0);
        cyc();
        check("t5_still_blk", 32'(bus.pt_valid), 32'h0);
        bus.ct_valid = 1'b0;

        // Asynchronous reset between edges with a word in flight.
        bus.key_valid = 1'b1;
        bus.key_data = 8'h01; cyc();
        bus.key_data = 8'h02; cyc();
        bus.key_valid = 1'b0;
        bus.ct_valid = 1'b1; bus.ct_data = 8'h40;
        cyc();
        bus.ct_valid = 1'b0;
        #1;
        check("t6_pre_pt", 32'(bus.pt_data), 32'h41);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_ar_vld", 32'(bus.pt_valid), 32'h0);
        check("t6_ar_dat", 32'(bus.pt_data), 32'h0);
        check("t6_ar_kc", 32'(key_count), 32'd0);
        check("t6_ar_msg", 32'(msg_count), 32'd0);
        check("t6_ar_kr", 32'(bus.key_ready), 32'h0);
        cyc();
        rst_n = 1'b1;

        // Counter wrap: first edge only pushes, every later edge pushes and fires.
        bus.key_valid = 1'b1;
        bus.ct_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.key_data = 8'(i * 7 + 3);
            bus.ct_data  = 8'(i);
            cyc();
        end
        check("wrap_max", 32'(msg_count), 32'hFF);
        cyc();
        check("wrap_zero", 32'(msg_count), 32'h00);
        bus.key_valid = 1'b0;
        bus.ct_valid  = 1'b0;
        cyc();
        cyc();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/otp_decipher.md
Name: otp_decipher

Overview:
- Receive side of the one-time-pad link: recovers plaintext as ciphertext XOR pad word.
- Pad words are preloaded into an internal pad FIFO. Each ciphertext word consumes exactly one pad word, in order. A consumed pad entry is wiped and never reused.
- Sits between the link receiver (ciphertext source) and the message sink. Pad words come from the key-distribution path.
- All three streams use valid/ready handshakes. A zeroize input wipes all key material.

Parameters:
- MSG_SIZE, 8, width of pad, ciphertext and plaintext words in bits.
- PAD_DEPTH, 4, pad FIFO entries. Must be a power of two and at least 2.
- CNT_W, 16, width of the decoded-message counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- zeroize  in  1  synchronous wipe of all pad and output state.
- key_valid  in  1  pad word offered.
- key_ready  out  1  pad FIFO can accept a word.
- key_data  in  MSG_SIZE  pad word.
- ct_valid  in  1  ciphertext word offered.
- ct_ready  out  1  ciphertext word can be accepted.
- ct_data  in  MSG_SIZE  ciphertext word.
- pt_valid  out  1  plaintext register holds a word.
- pt_ready  in  1  sink accepts the plaintext word.
- pt_data  out  MSG_SIZE  plaintext word.
- key_count  out  clog2(PAD_DEPTH)+1  unused pad words held.
- msg_count  out  CNT_W  ciphertext words decoded since reset or zeroize.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs go to 0 immediately.
  - Clears: pt_valid, pt_data, key_count, msg_count, FIFO pointers and all FIFO storage.
  - key_ready and ct_ready are 0 while reset is asserted.
- Reset mid-transfer: any in-flight plaintext word is lost, no partial state survives.
- Pad push: occurs when key_valid && key_ready, at the clock edge.
  - key_ready = !full && !zeroize.
  - When full, key_ready=0 and key_data is ignored. No overwrite.
- Decode fire: occurs when ct_valid && ct_ready.
  - ct_ready = !empty && !zeroize && (!pt_valid || pt_ready).
  - On fire: pt_data <= ct_data ^ head pad word; pt_valid <= 1; head entry written to 0; read pointer advances; msg_count increments.
  - Latency: plaintext is valid the cycle after the fire.
  - Back-to-back fires are allowed at one word per cycle when pt_ready is held at 1.
- Output stage has two states:
  - EMPTY (pt_valid=0) -> FULL on a fire.
  - FULL -> EMPTY when pt_ready=1 and there is no fire.
  - FULL -> FULL on pt_ready && fire (new word replaces the old one).
  - FULL with pt_ready=0: pt_data and pt_valid are held stable and ct_ready=0.
- Empty pad FIFO: ct_ready=0, so ciphertext is back-pressured and never decoded with a stale or zero pad.
- Push into an empty FIFO:
  - The new word is not usable by a decode in the same cycle, because ct_ready is computed from the registered count.
  - It is usable from the next cycle.
- Simultaneous push and fire when not full and not empty: key_count unchanged, both pointers advance.
- key_count is exact at all times, in the range 0..PAD_DEPTH.
- Pointers wrap modulo PAD_DEPTH. Full and empty are distinguished by key_count.
- msg_count wraps from 2^CNT_W-1 to 0 with no flag.
- Zeroize (synchronous, highest priority):
  - Clears all FIFO storage, pointers, key_count, msg_count, pt_data and pt_valid on the next edge.
  - A push or fire presented in that cycle is dropped: ready is 0, so no handshake completes.
- Arithmetic: bitwise XOR only; widths are all MSG_SIZE with no extension.
- pt_data is 0 whenever pt_valid=0 after reset or zeroize. After a normal drain, pt_data keeps its last value.

Test Plan:
- Reset then push pads 0x3C, 0xA5 -> key_count=2. Send ct 0x5F, 0x00 with pt_ready=1 -> pt_data 0x63 then 0xA5, one cycle after each fire; msg_count=2; key_count=0.
- Push 4 pads -> key_ready=0 and key_count=4. A 5th push held for 3 cycles is not accepted. Decode one ct -> key_ready=1 the next cycle, and the 5th push is accepted, exercising pointer wrap.
- key_count=0 with ct_valid=1 and ct 0x11 held -> ct_ready stays 0, no pt_valid. Push pad 0xFF -> decode fires the following cycle, pt_data=0xEE.
- 3 pads loaded, pt_ready=0 -> after the first fire pt_valid=1, ct_ready=0, pt_data stable for 5 cycles. Raise pt_ready with ct held -> one word per cycle, values match XOR of pads in push order.
- 2 pads loaded plus a pending pt word; assert zeroize in the same cycle as key_valid and ct_valid -> next cycle key_count=0, pt_valid=0, pt_data=0, msg_count=0. A subsequent ct is blocked.
- Assert rst_n=0 asynchronously mid-stream between clock edges -> outputs go to 0 before the next edge. Force msg_count to 0xFFFF with one more decode -> wraps to 0x0000.
